uart_frame_rx: RTL and testbench

//  Byte-stream deframer downstream of the uart receiver. Consumes received bytes
//  (new_value/recvd_data), finds frames [SYNC][LEN][LEN payload bytes][CHK],

---
 rtl/uart_frame_rx.sv | 156 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: deframes [SYNC][LEN][LEN payload][CHK] from the uart byte stream and releases only checksum-verified payloads.
// Latency: frame_ok and the first out_valid appear the cycle after the CHK byte is accepted; then one byte per cycle with out_ready high.
// Backpressure: out_valid/out_data/out_last hold while out_ready is low; uart bytes arriving during SEND are consumed and dropped (overrun).
// Ports: clk, rst_n (async active-low); uart side new_value/recvd_data/rx_error in, rx_clear out (1-cycle consume pulse);
//        stream side out_valid/out_data/out_last out, out_ready in; status pulses frame_ok/frame_err/overrun, level busy.
module uart_frame_rx #(
   parameter int         clock_frequency = 12000000,
   parameter int         baud_rate       = 9600,
   parameter int         max_payload     = 16,
   parameter logic [7:0] sync_byte       = 8'hAA,
   // ten characters of ten bit times each
   parameter int         timeout_cycles  = (clock_frequency / baud_rate) * 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       new_value,
   input  logic [7:0] recvd_data,
   input  logic       rx_error,
   output logic       rx_clear,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int LW = $clog2(max_payload + 1);
   localparam int AW = (max_payload > 1) ? $clog2(max_payload) : 1;
   localparam int TW = $clog2(timeout_cycles + 1);
   localparam logic [7:0]    MAX_LEN = 8'(max_payload);
   localparam logic [TW-1:0] TMO     = TW'(timeout_cycles);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

   state_t        state, state_nxt;
   logic [LW-1:0] len, wr_ptr, rd_ptr;
   logic [7:0]    sum, chk_sum;
   logic [TW-1:0] timer;
   logic [7:0]    mem [max_payload];

   logic accept, in_frame, timeout, xfer;
   logic ok_nxt, err_nxt, ovr_nxt, len_ld, buf_wr;

   // rx_clear is high for exactly the cycle after a take, which masks the
   // still-raised new_value so the same byte is never taken twice.
   assign accept   = new_value && !rx_clear;
   assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   assign timeout  = (timer == TMO);
   assign chk_sum  = sum + recvd_data;

   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_SEND);
   assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
   assign out_last  = out_valid && (rd_ptr == len - 1'b1);
   assign xfer      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Priority inside a frame: rx_error, then a received byte, then timeout.
   always_comb begin
      state_nxt = state;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      ovr_nxt   = 1'b0;
      len_ld    = 1'b0;
      buf_wr    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept && recvd_data == sync_byte) state_nxt = S_LEN;
         end
         S_LEN, S_PAYLOAD, S_CHK: begin
            if (rx_error) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else if (accept) begin
               case (state)
                  S_LEN: begin
                     if (recvd_data != 8'h00 && recvd_data <= MAX_LEN) begin
                        len_ld    = 1'b1;
                        state_nxt = S_PAYLOAD;
                     end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                     end
                  end
                  S_PAYLOAD: begin
                     buf_wr = 1'b1;
                     if (wr_ptr == len - 1'b1) state_nxt = S_CHK;
                  end
                  default: begin
                     if (chk_sum == 8'h00) begin
                        ok_nxt    = 1'b1;
                        state_nxt = S_SEND;
                     end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                     end
                  end
               endcase
            end else if (timeout) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_SEND: begin
            ovr_nxt = accept;
            if (xfer && out_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_clear  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         len       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         sum       <= 8'h00;
         timer     <= '0;
      end else begin
         rx_clear  <= accept;
         frame_ok  <= ok_nxt;
         frame_err <= err_nxt;
         overrun   <= ovr_nxt;
         if (len_ld) begin
            len    <= recvd_data[LW-1:0];
            sum    <= recvd_data;
            wr_ptr <= '0;
         end
         if (buf_wr) begin
            sum    <= chk_sum;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ok_nxt)    rd_ptr <= '0;
         else if (xfer) rd_ptr <= rd_ptr + 1'b1;
         // Idle gap counter: only runs between bytes of a frame in progress.
         if (!in_frame || accept || state_nxt == S_IDLE) timer <= '0;
         else                                           timer <= timer + 1'b1;
      end
   end

   // Payload storage needs no reset: it is only read after being written.
   always_ff @(posedge clk) begin
      if (buf_wr) mem[wr_ptr[AW-1:0]] <= recvd_data;
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;
   localparam int MAXP = 16;
   localparam int TMO  = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       new_value = 1'b0;
   logic [7:0] recvd_data = 8'h00;
   logic       rx_error = 1'b0;
   logic       out_ready = 1'b0;
   logic       rx_clear, out_valid, out_last, frame_ok, frame_err, overrun, busy;
   logic [7:0] out_data;

   int total = 0, bad = 0;
   int n_ok = 0, n_err = 0, n_ovr = 0;
   int exp_ok = 0, exp_err = 0, exp_ovr = 0;
   logic [7:0] got_dat[$];
   logic       got_last[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_frame_rx #(
      .clock_frequency(12000000),
      .baud_rate(9600),
      .max_payload(MAXP),
      .sync_byte(8'hAA),
      .timeout_cycles(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .new_value(new_value), .recvd_data(recvd_data),
      .rx_error(rx_error), .rx_clear(rx_clear), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .frame_ok(frame_ok), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: counts pulses, records transfers, checks hold-while-stalled.
   logic       stall_prev = 1'b0;
   logic [7:0] dat_prev = 8'h00;
   logic       last_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_ok)  n_ok++;
         if (frame_err) n_err++;
         if (overrun)   n_ovr++;
         check("ok_err_exclusive", 32'(frame_ok & frame_err), 0);
         if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(dat_prev));
            check("hold_last", 32'(out_last), 32'(last_prev));
         end
         if (out_valid && out_ready) begin
            got_dat.push_back(out_data);
            got_last.push_back(out_last);
         end
         stall_prev = out_valid && !out_ready;
         dat_prev   = out_data;
         last_prev  = out_last;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Uart model: hold the byte until the receiver acknowledges with rx_clear.
   // Returns 1 time unit after the clock edge that took the byte.
   task automatic send_byte(input logic [7:0] b);
      bit seen = 1'b0;
      @(posedge clk); #1;
      new_value  = 1'b1;
      recvd_data = b;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk); #1;
         if (rx_clear) seen = 1'b1;
      end
      if (!seen) check("rx_clear_timeout", 0, 1);
      new_value = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(posedge clk); #1;
         if (!busy) done = 1'b1;
      end
      check(tag, 32'(busy), 0);
      @(negedge clk); #1;
   endtask

   task automatic check_out(input string tag);
      check({tag, "_count"}, got_dat.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_dat.size(); i++) begin
         check({tag, "_data"}, 32'(got_dat[i]), 32'(exp_q[i]));
         check({tag, "_last"}, 32'(got_last[i]), (i == exp_q.size() - 1) ? 1 : 0);
      end
      got_dat.delete();
      got_last.delete();
      exp_q.delete();
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_n_ok"}, n_ok, exp_ok);
      check({tag, "_n_err"}, n_err, exp_err);
      check({tag, "_n_ovr"}, n_ovr, exp_ovr);
   endtask

   // Reference: checksum is the two's complement of (LEN + payload) mod 256.
   task automatic send_frame(input logic [7:0] pl[$], input bit corrupt, input string tag);
      int         s = pl.size();
      logic [7:0] chk;
      foreach (pl[i]) s += int'(pl[i]);
      chk = 8'((256 - (s % 256)) % 256);
      if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
      send_byte(8'hAA);
      send_byte(8'(pl.size()));
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(chk);
      if (corrupt) exp_err++;
      else begin
         exp_ok++;
         foreach (pl[i]) exp_q.push_back(pl[i]);
      end
      wait_idle({tag, "_idle"});
      check_out(tag);
      check_counts(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pl[$];
      logic [7:0] b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_clear", 32'(rx_clear), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_frame_ok", 32'(frame_ok), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;

      // 1: AA 02 10 20 CE
      out_ready = 1'b1;
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCE);
      check("t1_ok_latency", 32'(frame_ok), 1);
      check("t1_valid_latency", 32'(out_valid), 1);
      check("t1_first_data", 32'(out_data), 32'h10);
      exp_ok++;
      exp_q.push_back(8'h10); exp_q.push_back(8'h20);
      wait_idle("t1_idle");
      check_out("t1");
      check_counts("t1");

      // 2: bad checksum, then a one-byte frame whose payload/checksum are AA-ish
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCF);
      check("t2_err_pulse", 32'(frame_err), 1);
      check("t2_no_valid", 32'(out_valid), 0);
      exp_err++;
      wait_idle("t2a_idle");
      check_out("t2a");
      check_counts("t2a");
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA);
      exp_ok++;
      exp_q.push_back(8'h55);
      wait_idle("t2b_idle");
      check_out("t2b");
      check_counts("t2b");

      // 3: illegal lengths and idle garbage
      send_byte(8'hAA); send_byte(8'h00);
      check("t3_len0_err", 32'(frame_err), 1);
      exp_err++;
      send_byte(8'hAA); send_byte(8'(MAXP + 1));
      check("t3_len17_err", 32'(frame_err), 1);
      exp_err++;
      send_byte(8'h3C); send_byte(8'h7E);
      wait_idle("t3_idle");
      check_out("t3");
      check_counts("t3");

      // 4: 3-byte frame under backpressure with an overrun byte
      out_ready = 1'b0;
      pl = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      send_byte(8'hAA); send_byte(8'h03);
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(8'((256 - ((3 + int'(pl[0]) + int'(pl[1]) + int'(pl[2])) % 256)) % 256));
      check("t4_valid", 32'(out_valid), 1);
      exp_ok++;
      for (int idx = 0; idx < 3; idx++) begin
         repeat (5) @(posedge clk);
         if (idx == 0) begin
            send_byte(8'hAA);
            check("t4_overrun_pulse", 32'(overrun), 1);
            check("t4_still_busy", 32'(busy), 1);
            exp_ovr++;
         end
         @(posedge clk); #1;
         check("t4_data", 32'(out_data), 32'(pl[idx]));
         check("t4_last", 32'(out_last), (idx == 2) ? 1 : 0);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         exp_q.push_back(pl[idx]);
      end
      wait_idle("t4_idle");
      check_out("t4");
      check_counts("t4");

      // 5a: timeout mid-payload
      out_ready = 1'b1;
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
      repeat (150) @(posedge clk);
      #1;
      check("t5a_busy_before", 32'(busy), 1);
      check("t5a_no_err_before", n_err, exp_err);
      repeat (100) @(posedge clk);
      #1;
      check("t5a_idle_after", 32'(busy), 0);
      exp_err++;
      @(negedge clk); #1;
      check_counts("t5a");

      // 5b: rx_error mid-payload
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
      @(posedge clk); #1;
      rx_error = 1'b1;
      @(posedge clk); #1;
      rx_error = 1'b0;
      check("t5b_err_pulse", 32'(frame_err), 1);
      check("t5b_idle", 32'(busy), 0);
      exp_err++;
      wait_idle("t5b_idle2");
      check_out("t5b");
      check_counts("t5b");

      // 5c: reset during SEND
      out_ready = 1'b0;
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
      exp_ok++;
      @(posedge clk); #1;
      check("t5c_valid_before", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("t5c_valid_in_reset", 32'(out_valid), 0);
      check("t5c_busy_in_reset", 32'(busy), 0);
      check("t5c_ok_in_reset", 32'(frame_ok), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      wait_idle("t5c_idle");
      check_out("t5c");
      check_counts("t5c");

      // Randomized frames with idle garbage and occasional corrupted checksums
      for (int it = 0; it < 12; it++) begin
         int nj = $urandom_range(0, 2);
         int ln = $urandom_range(1, MAXP);
         bit bad_chk = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < nj; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h3C;
            send_byte(b);
         end
         pl.delete();
         for (int j = 0; j < ln; j++) pl.push_back(8'($urandom_range(0, 255)));
         send_frame(pl, bad_chk, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
